// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA plot arbiter and its helpers.
package vga_pkg;
   localparam int COORD_W      = 10;
   localparam int COLOR_W      = 3;
   localparam int VGA_X_W      = 8;
   localparam int VGA_Y_W      = 7;
   localparam int DEF_SCREEN_W = 160;
   localparam int DEF_SCREEN_H = 120;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_GRANT = 2'd2,
      ST_BUSY  = 2'd3
   } state_t;

   // Full-width compare so that e.g. x=261 is not mistaken for x=5 on an 8-bit bus.
   function automatic logic on_screen(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y,
                                      input int w, input int h);
      return (x < COORD_W'(w)) && (y < COORD_W'(h));
   endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after the pointer wins.
module rr_pick #(
   parameter int N     = 2,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [PTR_W-1:0] o_win,
   output logic             o_valid
);
   // Scan downward so the candidate closest to the pointer is written last.
   always_comb begin
      o_win   = '0;
      o_valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[(int'(i_ptr) + i) % N]) begin
            o_valid = 1'b1;
            o_win   = PTR_W'((int'(i_ptr) + i) % N);
         end
      end
   end
endmodule

// File: rtl/vga_plot_arbiter.sv
// Arbitrates whole draw operations from sprite engines onto one VGA adapter port,
// clips off-screen pixels and provides a built-in full-screen clear engine.
module vga_plot_arbiter
   import vga_pkg::*;
#(
   parameter int NUM_CLIENTS = 2,
   parameter int SCREEN_W    = DEF_SCREEN_W,
   parameter int SCREEN_H    = DEF_SCREEN_H,
   parameter int TIMEOUT     = 8192
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clear_req,
   input  logic [COLOR_W-1:0]             clear_color,
   input  logic [NUM_CLIENTS-1:0]         cl_req,
   output logic [NUM_CLIENTS-1:0]         cl_go,
   input  logic [COORD_W*NUM_CLIENTS-1:0] cl_x,
   input  logic [COORD_W*NUM_CLIENTS-1:0] cl_y,
   input  logic [COLOR_W*NUM_CLIENTS-1:0] cl_color,
   input  logic [NUM_CLIENTS-1:0]         cl_plot,
   input  logic [NUM_CLIENTS-1:0]         cl_done,
   output logic [NUM_CLIENTS-1:0]         cl_ack,
   output logic                           aborted,
   output logic                           busy,
   output logic [VGA_X_W-1:0]             vga_x,
   output logic [VGA_Y_W-1:0]             vga_y,
   output logic [COLOR_W-1:0]             vga_colour,
   output logic                           vga_plot,
   output state_t                         dbg_state
);
   localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int TMO_W = $clog2(TIMEOUT);

   state_t                   r_state, w_next;
   logic [PTR_W-1:0]         r_ptr, r_win, w_pick;
   logic                     w_pick_valid;
   logic [COORD_W-1:0]       r_cx, r_cy;
   logic [COLOR_W-1:0]       r_clr_color;
   logic [TMO_W-1:0]         r_tmo;
   logic                     r_seen;
   logic [COORD_W-1:0]       w_win_x, w_win_y;
   logic [COLOR_W-1:0]       w_win_color;
   logic                     w_win_plot, w_win_done, w_done_ok, w_tmo_hit, w_end, w_clear_last;
   logic [NUM_CLIENTS-1:0]   w_go, w_ack, r_go, r_ack;
   logic                     w_abort, r_abort, w_vp, r_vp;
   logic [VGA_X_W-1:0]       w_vx, r_vx;
   logic [VGA_Y_W-1:0]       w_vy, r_vy;
   logic [COLOR_W-1:0]       w_vc, r_vc;

   rr_pick #(.N(NUM_CLIENTS), .PTR_W(PTR_W)) u_pick (
      .i_req   (cl_req),
      .i_ptr   (r_ptr),
      .o_win   (w_pick),
      .o_valid (w_pick_valid)
   );

   assign w_win_x     = cl_x[COORD_W*int'(r_win) +: COORD_W];
   assign w_win_y     = cl_y[COORD_W*int'(r_win) +: COORD_W];
   assign w_win_color = cl_color[COLOR_W*int'(r_win) +: COLOR_W];
   assign w_win_plot  = cl_plot[r_win];
   assign w_win_done  = cl_done[r_win];

   // Handshake: cl_go pulses once per grant; the client then streams pixels and raises
   // cl_done. Done only counts once a plot has been seen in this grant (same cycle included),
   // which masks a done level left over from the previous operation. cl_ack closes the grant.
   assign w_done_ok    = w_win_done && (r_seen || w_win_plot);
   assign w_tmo_hit    = (r_tmo == TMO_W'(TIMEOUT - 1));
   assign w_end        = w_done_ok || w_tmo_hit;
   assign w_clear_last = (r_cx == COORD_W'(SCREEN_W - 1)) && (r_cy == COORD_W'(SCREEN_H - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (clear_req)         w_next = ST_CLEAR;
            else if (w_pick_valid) w_next = ST_GRANT;
         end
         ST_CLEAR: if (w_clear_last) w_next = ST_IDLE;
         ST_GRANT: w_next = ST_BUSY;
         ST_BUSY:  if (w_end) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_go    = '0;
      w_ack   = '0;
      w_abort = 1'b0;
      w_vx    = '0;
      w_vy    = '0;
      w_vc    = '0;
      w_vp    = 1'b0;
      case (r_state)
         ST_IDLE: if (w_next == ST_GRANT) w_go[w_pick] = 1'b1;
         ST_CLEAR: begin
            w_vx = r_cx[VGA_X_W-1:0];
            w_vy = r_cy[VGA_Y_W-1:0];
            w_vc = r_clr_color;
            w_vp = 1'b1;
         end
         ST_BUSY: begin
            w_vx = w_win_x[VGA_X_W-1:0];
            w_vy = w_win_y[VGA_Y_W-1:0];
            w_vc = w_win_color;
            w_vp = w_win_plot && on_screen(w_win_x, w_win_y, SCREEN_W, SCREEN_H);
            if (w_end) begin
               w_ack[r_win] = 1'b1;
               w_abort      = !w_done_ok;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_go    <= '0;
         r_ack   <= '0;
         r_abort <= 1'b0;
         r_vx    <= '0;
         r_vy    <= '0;
         r_vc    <= '0;
         r_vp    <= 1'b0;
      end else begin
         r_go    <= w_go;
         r_ack   <= w_ack;
         r_abort <= w_abort;
         r_vx    <= w_vx;
         r_vy    <= w_vy;
         r_vc    <= w_vc;
         r_vp    <= w_vp;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr       <= '0;
         r_win       <= '0;
         r_cx        <= '0;
         r_cy        <= '0;
         r_tmo       <= '0;
         r_seen      <= 1'b0;
         r_clr_color <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cx   <= '0;
               r_cy   <= '0;
               r_tmo  <= '0;
               r_seen <= 1'b0;
               if (clear_req)            r_clr_color <= clear_color;
               if (w_next == ST_GRANT)   r_win       <= w_pick;
            end
            ST_CLEAR: begin
               if (r_cx == COORD_W'(SCREEN_W - 1)) begin
                  r_cx <= '0;
                  r_cy <= r_cy + 1'b1;
               end else begin
                  r_cx <= r_cx + 1'b1;
               end
            end
            ST_BUSY: begin
               r_tmo <= r_tmo + 1'b1;
               if (w_win_plot) r_seen <= 1'b1;
               if (w_end) r_ptr <= (r_win == PTR_W'(NUM_CLIENTS - 1)) ? '0 : r_win + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign cl_go      = r_go;
   assign cl_ack     = r_ack;
   assign aborted    = r_abort;
   assign vga_x      = r_vx;
   assign vga_y      = r_vy;
   assign vga_colour = r_vc;
   assign vga_plot   = r_vp;
   assign busy       = (r_state != ST_IDLE);
   assign dbg_state  = r_state;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: directed scenarios plus randomized client traffic
// checked against a round-robin/clipping reference model.
module tb_vga_plot_arbiter;
   import vga_pkg::*;

   localparam int NC  = 2;
   localparam int SW  = 160;
   localparam int SH  = 120;
   localparam int TMO = 8192;
   localparam int XW  = 10 * NC;
   localparam int CW  = 3 * NC;

   logic            clk = 1'b0;
   logic            reset, clear_req;
   logic [2:0]      clear_color;
   logic [NC-1:0]   cl_req, cl_go, cl_plot, cl_done, cl_ack;
   logic [XW-1:0]   cl_x, cl_y;
   logic [CW-1:0]   cl_color;
   logic            aborted, busy, vga_plot;
   logic [7:0]      vga_x;
   logic [6:0]      vga_y;
   logic [2:0]      vga_colour;
   state_t          dbg_state;

   int              total = 0;
   int              bad   = 0;
   int              m_ptr = 0;
   logic [17:0]     exp_q[$];
   logic [9:0]      dir_x[$], dir_y[$];

   vga_plot_arbiter #(.NUM_CLIENTS(NC), .SCREEN_W(SW), .SCREEN_H(SH), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .clear_req(clear_req), .clear_color(clear_color),
      .cl_req(cl_req), .cl_go(cl_go), .cl_x(cl_x), .cl_y(cl_y), .cl_color(cl_color),
      .cl_plot(cl_plot), .cl_done(cl_done), .cl_ack(cl_ack), .aborted(aborted), .busy(busy),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference arbitration: first requester at or after the model's pointer.
   function automatic int model_pick(input logic [NC-1:0] req);
      for (int i = 0; i < NC; i++)
         if (req[(m_ptr + i) % NC]) return (m_ptr + i) % NC;
      return 0;
   endfunction

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_plot"}, 32'(vga_plot), 32'(0));
      chk({tag, "_x"}, 32'(vga_x), 32'(0));
      chk({tag, "_y"}, 32'(vga_y), 32'(0));
      chk({tag, "_colour"}, 32'(vga_colour), 32'(0));
      chk({tag, "_go"}, 32'(cl_go), 32'(0));
      chk({tag, "_ack"}, 32'(cl_ack), 32'(0));
      chk({tag, "_aborted"}, 32'(aborted), 32'(0));
      chk({tag, "_busy"}, 32'(busy), 32'(0));
   endtask

   // One client operation: request, wait for go, stream pixels, then done (unless hang).
   task automatic serve(input logic [NC-1:0] req, input int npix, input bit stale, input bit hang);
      int win, t, sent, bc;
      bit seen, ended, d_plot, d_done, exp_plot, exp_end, exp_abort;
      logic [9:0] px, py;
      logic [2:0] pc;
      win     = model_pick(req);
      cl_req  = req;
      cl_done = stale ? req : '0;
      t = 0;
      while (cl_go == '0 && t < 8) begin
         tick();
         t++;
      end
      chk("go_winner", 32'(cl_go), 32'(1) << win);
      chk("busy_grant", 32'(busy), 32'(1));
      chk("no_plot_grant", 32'(vga_plot), 32'(0));
      tick();
      chk("go_pulse", 32'(cl_go), 32'(0));
      seen = 0;
      ended = 0;
      sent = 0;
      for (bc = 1; bc <= TMO + 2 && !ended; bc++) begin
         d_plot = 0;
         d_done = stale;
         px = 10'($urandom_range(0, 199));
         py = 10'($urandom_range(0, 139));
         pc = 3'($urandom_range(0, 7));
         if (stale && bc < 4) begin
            d_plot = 0;
         end else if (sent < npix) begin
            d_plot = (stale || dir_x.size() > 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (d_plot && dir_x.size() > 0) begin
               px = dir_x.pop_front();
               py = dir_y.pop_front();
            end
            if (d_plot) sent++;
         end else begin
            d_done = !hang;
         end
         cl_x     = XW'($urandom);
         cl_y     = XW'($urandom);
         cl_color = CW'($urandom);
         cl_plot  = NC'($urandom);
         cl_done  = NC'($urandom);
         cl_x[win*10 +: 10]  = px;
         cl_y[win*10 +: 10]  = py;
         cl_color[win*3 +: 3] = pc;
         cl_plot[win] = d_plot;
         cl_done[win] = d_done;
         exp_plot = d_plot && (px < SW) && (py < SH);
         if (exp_plot) exp_q.push_back({px[7:0], py[6:0], pc});
         seen      = seen || d_plot;
         exp_end   = (d_done && seen) || (bc == TMO);
         exp_abort = !(d_done && seen) && (bc == TMO);
         tick();
         chk("pix_latency", 32'(vga_plot), 32'(exp_plot));
         if (vga_plot && exp_q.size() > 0)
            chk("pix_value", 32'({vga_x, vga_y, vga_colour}), 32'(exp_q.pop_front()));
         chk("ack", 32'(cl_ack), exp_end ? (32'(1) << win) : 32'(0));
         chk("aborted", 32'(aborted), 32'(exp_abort));
         chk("go_quiet", 32'(cl_go), 32'(0));
         if (exp_end) ended = 1;
      end
      m_ptr   = (win + 1) % NC;
      cl_plot = '0;
      cl_done = '0;
      chk("idle_gap", 32'(busy), 32'(0));
      chk("queue_empty", 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      int n, k, plot_cnt, busy_cnt, pix_err, first_tick;
      logic [14:0] last_xy;
      reset = 1'b1; clear_req = 1'b0; clear_color = '0;
      cl_req = '0; cl_x = '0; cl_y = '0; cl_color = '0; cl_plot = '0; cl_done = '0;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
      reset = 1'b0;
      tick();

      // Reset in the middle of a clear
      clear_color = 3'($urandom_range(0, 7));
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      n = 0; k = 0;
      while (n < 500 && k < 600) begin
         tick();
         k++;
         if (vga_plot) n++;
      end
      chk("pre_reset_pixels", 32'(n), 32'(500));
      #2 reset = 1'b1;
      #1 chk_outputs_zero("mid_reset");
      @(negedge clk);
      reset = 1'b0;
      m_ptr = 0;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (vga_plot || busy) n++;
      end
      chk("post_reset_quiet", 32'(n), 32'(0));

      // Full clear; clear_req wins over pending client requests
      clear_color = 3'b010; clear_req = 1'b1; cl_req = 2'b11;
      tick();
      chk("clear_beats_req", 32'(cl_go), 32'(0));
      chk("clear_state", 32'(dbg_state), 32'(ST_CLEAR));
      clear_req = 1'b0; cl_req = '0; clear_color = 3'b101;
      plot_cnt = 0; pix_err = 0; first_tick = -1; last_xy = '0;
      busy_cnt = busy ? 1 : 0;
      for (int t = 2; t <= SW * SH + 10; t++) begin
         tick();
         if (busy) busy_cnt++;
         if (vga_plot) begin
            if (first_tick < 0) first_tick = t;
            if ({vga_x, vga_y, vga_colour} !== {8'(plot_cnt % SW), 7'(plot_cnt / SW), 3'b010})
               pix_err++;
            last_xy = {vga_x, vga_y};
            plot_cnt++;
         end
      end
      chk("clear_count", 32'(plot_cnt), 32'(SW * SH));
      chk("clear_pixels", 32'(pix_err), 32'(0));
      chk("clear_first_latency", 32'(first_tick), 32'(2));
      chk("clear_last", 32'(last_xy), 32'({8'd159, 7'd119}));
      chk("clear_busy_cycles", 32'(busy_cnt), 32'(SW * SH));

      // Round-robin with both clients requesting continuously
      for (int i = 0; i < 4; i++) serve(2'b11, 4, 1'b0, 1'b0);

      // Clipping, including coordinates whose low bits alias on-screen positions
      dir_x = '{10'd159, 10'd160, 10'd5, 10'd261, 10'd10};
      dir_y = '{10'd119, 10'd5, 10'd120, 10'd5, 10'd131};
      serve(2'b10, 5, 1'b0, 1'b0);

      // Stale done from a previous operation
      serve(2'b01, 2, 1'b1, 1'b0);

      // Timeout, then the other requester is served
      serve(2'b11, 3, 1'b0, 1'b1);
      serve(2'b11, 2, 1'b0, 1'b0);

      // Randomized traffic with idle gaps
      for (int i = 0; i < 10; i++) begin
         serve(NC'($urandom_range(1, 3)), $urandom_range(1, 6), 1'b0, 1'b0);
         cl_req = '0;
         n = $urandom_range(0, 2);
         for (int j = 0; j < n; j++) begin
            tick();
            chk("idle_hold", 32'(busy), 32'(0));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
